// File: rtl/hazard_unit.sv
// Hazard unit: shadow pipeline of in-flight destinations driving
// operand forwarding, load-use stalls, redirect flushes and a stall counter.
module hazard_unit #(
  parameter int ADDR_W     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_dst,
  input  logic              id_regwr,
  input  logic              id_is_load,
  input  logic              redirect,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall,
  output logic              flush_id,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic              regwr;
    logic              is_load;
    logic [ADDR_W-1:0] dst;
  } entry_t;

  localparam logic [1:0] LD_IDX = 2'(1 + LOAD_LAT);

  entry_t           tbl_q [1:FWD_STAGES];
  entry_t           tbl_d [1:FWD_STAGES];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       ld_a;
  logic       ld_b;
  logic       hazard;
  logic       flush;
  logic       stall_i;
  logic       issue;

  function automatic logic hit(
    input entry_t            e,
    input logic [ADDR_W-1:0] s,
    input logic              used
  );
    return used && e.valid && e.regwr &&
           (e.dst == s) && (s != '0);
  endfunction

  // Scan oldest to youngest so the youngest match is left standing.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (hit(tbl_q[k], id_rs, id_uses_rs)) begin
        sel_a = 2'(k);
        ld_a  = tbl_q[k].is_load;
      end
      if (hit(tbl_q[k], id_rt, id_uses_rt)) begin
        sel_b = 2'(k);
        ld_b  = tbl_q[k].is_load;
      end
    end
  end

  always_comb begin
    flush   = (DELAY_SLOT == 0) && redirect;
    hazard  = (ld_a && (sel_a < LD_IDX)) ||
              (ld_b && (sel_b < LD_IDX));
    stall_i = id_valid && hazard && !flush;
    issue   = id_valid && !stall_i && !flush;
  end

  always_comb begin
    fwd_sel_a   = stall_i ? 2'd0 : sel_a;
    fwd_sel_b   = stall_i ? 2'd0 : sel_b;
    stall       = stall_i;
    flush_id    = flush;
    stall_count = cnt_q;
  end

  always_comb begin
    tbl_d[1] = '0;
    if (issue) begin
      tbl_d[1].valid   = 1'b1;
      tbl_d[1].regwr   = id_regwr;
      tbl_d[1].is_load = id_is_load;
      tbl_d[1].dst     = id_dst;
    end
    for (int k = 2; k <= FWD_STAGES; k++) begin
      tbl_d[k] = tbl_q[k-1];
    end
    cnt_d = cnt_q;
    if (stall_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        tbl_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        tbl_q[k] <= tbl_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
